// File: rtl/mem_access_unit_if.sv
// CPU-side request/response bundle for mem_access_unit.
// Latency: none, this is wiring only.
// Backpressure: req_valid/req_ready on requests, rsp_valid/rsp_ready on responses.
//
// Signals:
//   req_valid/req_ready          request handshake
//   req_write/req_size/req_unsigned/req_addr/req_wdata   request fields
//   rsp_valid/rsp_ready          response handshake
//   rsp_rdata/rsp_err            response fields
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  // CPU side drives requests and consumes responses.
  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  // Access unit side.
  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit between a CPU request port and a big-endian data memory.
// Latency accept->rsp_valid: 1 error, 2 load/word store, 3 byte/half store (RMW).
// Backpressure: one access in flight; req_ready low until the response is consumed.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   cpu             request/response bundle (slave side)
//   MemAddr         registered byte address to memory
//   MemWriteData    registered write word, MSB = byte at MemAddr
//   MemWrite        registered write enable, memory samples it on falling clk
//   MemReadData     combinational big-endian read of the word at MemAddr
module mem_access_unit #(
  parameter int unsigned MEM_BYTES = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_access_unit_if.slave   cpu,
  output logic [31:0]        MemAddr,
  output logic [31:0]        MemWriteData,
  output logic               MemWrite,
  input  logic [31:0]        MemReadData
);

  localparam logic [31:0] LAST_ADDR = 32'(MEM_BYTES - 4);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      state_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic [31:0] rsp_rdata_q;
  logic        mem_write_q;
  logic [31:0] mem_addr_q;   // doubles as the latched request address
  logic [31:0] mem_wdata_q;
  logic        write_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [15:0] wdata_q;      // only the sub-word part is needed after accept

  logic        accept;
  logic        misalign;
  logic        req_err;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  assign accept = cpu.req_valid & req_ready_q;

  always_comb begin
    misalign = 1'b0;
    case (cpu.req_size)
      2'b01:   misalign = cpu.req_addr[0];
      2'b10:   misalign = (cpu.req_addr[1:0] != 2'b00);
      default: misalign = 1'b0;
    endcase
    req_err = (cpu.req_size == 2'b11) | misalign | (cpu.req_addr > LAST_ADDR);
  end

  // The addressed byte is always the MSB of the big-endian read word.
  always_comb begin
    load_data = MemReadData;
    case (size_q)
      2'b00:   load_data = {{24{~uns_q & MemReadData[31]}}, MemReadData[31:24]};
      2'b01:   load_data = {{16{~uns_q & MemReadData[31]}}, MemReadData[31:16]};
      default: load_data = MemReadData;
    endcase
  end

  assign merge_data = (size_q == 2'b00) ? {wdata_q[7:0], MemReadData[23:0]}
                                        : {wdata_q, MemReadData[15:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      write_q     <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      wdata_q     <= 16'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            req_ready_q <= 1'b0;
            write_q     <= cpu.req_write;
            size_q      <= cpu.req_size;
            uns_q       <= cpu.req_unsigned;
            wdata_q     <= cpu.req_wdata[15:0];
            mem_addr_q  <= cpu.req_addr;
            if (req_err) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= 32'h0;
            end else if (cpu.req_write && cpu.req_size == 2'b10) begin
              state_q     <= WR;
              mem_wdata_q <= cpu.req_wdata;
              mem_write_q <= 1'b1;
            end else begin
              // Loads and sub-word stores both need the current word first.
              state_q <= RD;
            end
          end else begin
            // Raises ready on the first edge after reset release.
            req_ready_q <= 1'b1;
          end
        end
        RD: begin
          if (write_q) begin
            state_q     <= WR;
            mem_wdata_q <= merge_data;
            mem_write_q <= 1'b1;
          end else begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= load_data;
          end
        end
        WR: begin
          state_q     <= RESP;
          mem_write_q <= 1'b0;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= 32'h0;
        end
        RESP: begin
          if (cpu.rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          mem_write_q <= 1'b0;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign cpu.req_ready = req_ready_q;
  assign cpu.rsp_valid = rsp_valid_q;
  assign cpu.rsp_err   = rsp_err_q;
  assign cpu.rsp_rdata = rsp_rdata_q;
  assign MemAddr       = mem_addr_q;
  assign MemWriteData  = mem_wdata_q;
  assign MemWrite      = mem_write_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 32-byte big-endian memory model.
module tb_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] MemAddr;
  logic [31:0] MemWriteData;
  logic        MemWrite;
  logic [31:0] MemReadData;
  logic [7:0]  mem [32];

  int checks = 0;
  int errors = 0;

  mem_access_unit_if bus ();

  mem_access_unit #(.MEM_BYTES(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cpu          (bus.slave),
    .MemAddr      (MemAddr),
    .MemWriteData (MemWriteData),
    .MemWrite     (MemWrite),
    .MemReadData  (MemReadData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: combinational big-endian read, write on falling edge.
  logic [4:0] ma;
  assign ma = MemAddr[4:0];
  assign MemReadData = {mem[ma], mem[5'(ma + 5'd1)], mem[5'(ma + 5'd2)], mem[5'(ma + 5'd3)]};

  always @(negedge clk) begin
    if (MemWrite) begin
      mem[ma]             = MemWriteData[31:24];
      mem[5'(ma + 5'd1)]  = MemWriteData[23:16];
      mem[5'(ma + 5'd2)]  = MemWriteData[15:8];
      mem[5'(ma + 5'd3)]  = MemWriteData[7:0];
    end
  end

  function automatic logic [31:0] memw(input int a);
    return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete access: drive, accept, measure latency and write pulses,
  // optionally hold the response for 'hold' cycles, then consume it.
  task automatic access(input string tag, input logic w, input logic [1:0] sz,
                        input logic un, input logic [31:0] a, input logic [31:0] d,
                        input int exp_lat, input logic [31:0] exp_rd,
                        input logic exp_err, input int hold);
    int lat;
    int wr_cnt;
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_write    = w;
    bus.req_size     = sz;
    bus.req_unsigned = un;
    bus.req_addr     = a;
    bus.req_wdata    = d;
    chk({tag, ".req_ready"}, 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    // Scramble the request inputs; the in-flight access must ignore them.
    bus.req_valid    = 1'b0;
    bus.req_write    = ~w;
    bus.req_size     = 2'b11;
    bus.req_unsigned = ~un;
    bus.req_addr     = 32'h0000_0003;
    bus.req_wdata    = 32'hFFFF_FFFF;
    lat    = 1;
    wr_cnt = 0;
    while (!bus.rsp_valid && lat < 10) begin
      if (MemWrite) wr_cnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".rdata"}, bus.rsp_rdata, exp_rd);
    chk({tag, ".err"}, 32'(bus.rsp_err), 32'(exp_err));
    chk({tag, ".writes"}, 32'(wr_cnt), (w && !exp_err) ? 32'd1 : 32'd0);
    for (int i = 0; i < hold; i++) begin
      bus.req_valid = 1'b1;   // a pending request must not be accepted meanwhile
      @(posedge clk);
      #1;
      chk({tag, ".hold_valid"}, 32'(bus.rsp_valid), 32'd1);
      chk({tag, ".hold_rdata"}, bus.rsp_rdata, exp_rd);
      chk({tag, ".hold_ready"}, 32'(bus.req_ready), 32'd0);
      chk({tag, ".hold_memwrite"}, 32'(MemWrite), 32'd0);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    chk({tag, ".consumed"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, ".ready_again"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h0;
    bus.rsp_ready    = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst.req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst.rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rst.rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst.MemWrite", 32'(MemWrite), 32'd0);
    chk("rst.MemAddr", MemAddr, 32'h0);
    chk("rst.MemWriteData", MemWriteData, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst.ready_after_release", 32'(bus.req_ready), 32'd1);

    // Word store then word load.
    access("st_w08", 1'b1, 2'b10, 1'b0, 32'h08, 32'hDEAD_BEEF, 2, 32'h0, 1'b0, 0);
    chk("mem8_after_sw", memw(8), 32'hDEAD_BEEF);
    access("ld_w08", 1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 2, 32'hDEAD_BEEF, 1'b0, 0);

    // Byte store (RMW) and byte loads.
    access("st_b09", 1'b1, 2'b00, 1'b0, 32'h09, 32'h0000_0055, 3, 32'h0, 1'b0, 0);
    chk("mem8_after_sb", memw(8), 32'hDE55_BEEF);
    chk("mem12_after_sb", memw(12), 32'h0);
    access("ld_b09s", 1'b0, 2'b00, 1'b0, 32'h09, 32'h0, 2, 32'h0000_0055, 1'b0, 0);
    access("ld_b08s", 1'b0, 2'b00, 1'b0, 32'h08, 32'h0, 2, 32'hFFFF_FFDE, 1'b0, 0);
    access("ld_b08u", 1'b0, 2'b00, 1'b1, 32'h08, 32'h0, 2, 32'h0000_00DE, 1'b0, 0);

    // Halfword loads and store.
    access("ld_h0As", 1'b0, 2'b01, 1'b0, 32'h0A, 32'h0, 2, 32'hFFFF_BEEF, 1'b0, 0);
    access("ld_h0Au", 1'b0, 2'b01, 1'b1, 32'h0A, 32'h0, 2, 32'h0000_BEEF, 1'b0, 0);
    access("st_h0A", 1'b1, 2'b01, 1'b0, 32'h0A, 32'hABCD_1234, 3, 32'h0, 1'b0, 0);
    chk("mem8_after_sh", memw(8), 32'hDE55_1234);

    // Error cases: one-cycle response, no write.
    access("err_ldw06", 1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 1, 32'h0, 1'b1, 0);
    access("err_sth03", 1'b1, 2'b01, 1'b0, 32'h03, 32'h0000_7777, 1, 32'h0, 1'b1, 0);
    access("err_size3", 1'b0, 2'b11, 1'b0, 32'h00, 32'h0, 1, 32'h0, 1'b1, 0);
    access("err_stw1D", 1'b1, 2'b10, 1'b0, 32'h1D, 32'h1111_1111, 1, 32'h0, 1'b1, 0);
    access("err_stb1D", 1'b1, 2'b00, 1'b0, 32'h1D, 32'h0000_0099, 1, 32'h0, 1'b1, 0);
    chk("mem0_after_err", memw(0), 32'h0);
    chk("mem8_after_err", memw(8), 32'hDE55_1234);
    chk("mem28_after_err", memw(28), 32'h0);

    // Highest legal word address.
    access("st_w1C", 1'b1, 2'b10, 1'b0, 32'h1C, 32'h0102_0304, 2, 32'h0, 1'b0, 0);
    access("ld_w1C", 1'b0, 2'b10, 1'b0, 32'h1C, 32'h0, 2, 32'h0102_0304, 1'b0, 0);

    // Response held off for 5 cycles, then immediate next access.
    access("bp_ldw08", 1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 2, 32'hDE55_1234, 1'b0, 5);
    access("bp_next", 1'b0, 2'b01, 1'b1, 32'h08, 32'h0, 2, 32'h0000_DE55, 1'b0, 0);

    // Reset asserted during WR, before the falling edge.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_size  = 2'b10;
    bus.req_addr  = 32'h10;
    bus.req_wdata = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    chk("rstwr.memwrite_hi", 32'(MemWrite), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstwr.memwrite_drop", 32'(MemWrite), 32'd0);
    chk("rstwr.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rstwr.req_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    #1;
    chk("rstwr.mem16", memw(16), 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rstwr.ready_after", 32'(bus.req_ready), 32'd1);
    chk("rstwr.no_rsp", 32'(bus.rsp_valid), 32'd0);
    access("rstwr_ld10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, 32'h0, 1'b0, 0);
    chk("mem8_final", memw(8), 32'hDE55_1234);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter MEM_BYTES, default 32, meaning byte capacity of the attached data memory.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  CPU-side access request present.
REQ-005 req_ready  output  1  unit accepts a request this cycle.
REQ-006 req_write  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  CPU consumes response.
REQ-013 rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-014 rsp_err  output  1  request rejected, no memory write performed.
REQ-015 MemAddr  output  32  byte address to data memory.
REQ-016 MemWriteData  output  32  word to data memory, MSB = byte at MemAddr.
REQ-017 MemWrite  output  1  data-memory write enable, sampled by memory on falling clk.
REQ-018 MemReadData  input  32  combinational memory read, big-endian: [31:24] = byte at MemAddr, [7:0] = byte at MemAddr+3.

Function
REQ-019 FSM states IDLE, RD, WR, RESP; req_ready SHALL be 1 only in IDLE.
REQ-020 A handshake (req_valid & req_ready) SHALL latch write, size, unsigned, addr and wdata into internal registers.
REQ-021 Error check at accept: error if req_size = 11, or addr misaligned (half: addr[0]=1; word: addr[1:0]!=0), or addr > MEM_BYTES-4; error requests SHALL go IDLE -> RESP with rsp_err = 1.
REQ-022 Load: IDLE -> RD -> RESP; in RD MemAddr = latched addr, MemReadData captured at the RD->RESP edge.
REQ-023 Word store: IDLE -> WR -> RESP; MemWriteData = latched wdata.
REQ-024 Byte/half store (read-modify-write): IDLE -> RD -> WR -> RESP; WR word = read word with [31:24] (byte) or [31:16] (half) replaced by wdata[7:0] / wdata[15:0], bytes [23:0] / [15:0] unchanged.
REQ-025 MemWrite SHALL be a registered output, 1 exactly for the single WR cycle, so exactly one falling edge writes; 0 in all other states.
REQ-026 MemAddr and MemWriteData SHALL be registered and stable across the entire RD and WR cycles.
REQ-027 Load extraction: byte = MemReadData[31:24], half = MemReadData[31:16], word = MemReadData; extended to 32 bits per latched unsigned flag.
REQ-028 Latency from accept to rsp_valid: 2 cycles load/word store, 3 cycles byte/half store, 1 cycle error.
REQ-029 RESP: rsp_valid = 1 with rsp_rdata/rsp_err held stable until rsp_ready = 1; on that edge -> IDLE.
REQ-030 No new request accepted while RESP is held (back-pressure); next accept earliest the cycle after response consumed.
REQ-031 req_* inputs changing after accept SHALL have no effect on the in-flight access.

Reset
REQ-032 rst_n = 0 SHALL immediately force state IDLE, MemWrite = 0, MemAddr = 0, MemWriteData = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, req_ready = 0 while asserted.
REQ-033 Reset asserted during WR before the falling edge SHALL suppress that write; in-flight request discarded, no response produced.
REQ-034 After rst_n deasserts, req_ready = 1 from the first rising edge.

Verification
REQ-035 Word store addr 0x08 data 0xDEADBEEF, then word load 0x08 -> MemWrite high one cycle, load rsp_rdata = 0xDEADBEEF, rsp_err = 0, latency 2.
REQ-036 Memory bytes 8..11 = DE AD BE EF; byte store addr 0x09 data 0x55 -> bytes become DE 55 BE EF; signed byte load 0x09 = 0x00000055; signed byte load 0x08 = 0xFFFFFFDE; unsigned = 0x000000DE.
REQ-037 Halfword load 0x0A signed from BE EF -> 0xFFFFBEEF; unsigned -> 0x0000BEEF; half store 0x0A data 0x1234 -> bytes 10..11 = 12 34, bytes 8..9 unchanged.
REQ-038 Errors: word load 0x06, half store 0x03, size 11, word store 0x1D (MEM_BYTES=32) -> rsp_err = 1 after 1 cycle, MemWrite never asserts, memory unchanged.
REQ-039 rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready = 0 throughout; accept resumes cycle after rsp_ready = 1.
REQ-040 rst_n pulled low mid-WR before falling edge -> MemWrite drops immediately, target bytes unchanged, rsp_valid = 0, req_ready = 1 after release.
